mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
//  Byte-stream program/data loader: the write-side counterpart of the end-of-run RF/DMEM dump.
//  Accepts framed bytes on a valid/ready link and assembles them into words.
//  Writes the words into IMEM or DMEM through their write ports.
//  Holds the pipeline CPU in reset (cpu_reset_b=0) until a GO command; sits between bench/host link and pipeline_cpu memories.
// PARAMETERS
//  IMEM_AW  8   IMEM word-address width
//  DMEM_AW  8   DMEM word-address width
//  IMEM_DW  32  IMEM word width, bits (multiple of 8)
//  DMEM_DW  64  DMEM word width, bits (multiple of 8)
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  reset_b      in   1        synchronous, active-low reset
//  rx_valid     in   1        byte valid from host link
//  rx_data      in   8        byte payload
//  rx_ready     out  1        loader accepts byte; transfer when rx_valid&rx_ready at posedge
//  imem_we      out  1        IMEM write strobe, 1-cycle pulse
//  imem_addr    out  IMEM_AW  IMEM word address
//  imem_wdata   out  IMEM_DW  IMEM write data
//  dmem_we      out  1        DMEM write strobe, 1-cycle pulse
//  dmem_addr    out  DMEM_AW  DMEM word address
//  dmem_wdata   out  DMEM_DW  DMEM write data
//  cpu_reset_b  out  1        active-low reset to pipeline_cpu; released by GO
//  load_done    out  1        GO received, loader idle until reset_b
//  err          out  1        sticky: unknown command byte seen
// BEHAVIOUR
//  Reset (reset_b=0 at posedge):
//  - state=IDLE; rx_ready=1; *_we=0; addr/wdata=0; cpu_reset_b=0; load_done=0; err=0.
//  - Any partial frame or word is discarded.
//  Frame layout: CMD, LEN_LO, LEN_HI, ADR_LO, ADR_HI, then LEN words, each word LSB byte first.
//  - CMD 8'hA1 selects IMEM; CMD 8'hD1 selects DMEM.
//  - CMD 8'h5A is GO and carries no further bytes.
//  - LEN is a 16-bit word count.
//  - ADR is the 16-bit start word address, truncated to IMEM_AW/DMEM_AW.
//  FSM states: IDLE, LEN0, LEN1, ADR0, ADR1, DATA, WRITE, DONE.
//  - IDLE: on A1/D1 latch target -> LEN0.
//  - IDLE: on 5A -> DONE; cpu_reset_b and load_done set 1 the next cycle.
//  - IDLE: on any other byte, set err=1 (sticky) and stay in IDLE.
//  - LEN0 -> LEN1 -> ADR0 -> ADR1, one accepted byte each.
//  - ADR1 exit: if LEN==0 -> IDLE with no write; else -> DATA.
//  - DATA: shift bytes in LSB-first; bytes per word = DW/8 of the target.
//  - DATA: the last byte of a word -> WRITE.
//  - WRITE: 1 cycle; target we=1 with addr/wdata stable; rx_ready=0.
//  - WRITE exit: addr+1 (wraps mod 2^AW), remaining-1; remaining==0 -> IDLE, else -> DATA.
//  - DONE: rx_ready=0; absorbing until reset_b.
//  - Only one of imem_we/dmem_we is ever high.
//  Timing:
//  - rx_ready=1 in IDLE..DATA; 0 in WRITE and DONE.
//  - Write latency: we pulses the cycle after the last byte of the word is accepted.
//  - Throughput: one word per DW/8+1 cycles at full rx_valid.
//  - rx_valid=0 stalls in place; no timeout.
//  - rx_data is ignored when rx_valid=0.
//  Boundaries:
//  - Address wrap: 8'hFF+1 -> 8'h00; writes continue.
//  - LEN=16'hFFFF is legal.
//  - Multiple IMEM/DMEM frames in any order are allowed before GO.
//  - Reset mid-frame or mid-word: no write is issued and cpu_reset_b returns to 0.
//  - Unknown CMD does not stop later valid frames.
// STRUCTURE
//  loader_pkg:
//  - typedef enum logic [2:0] ldr_state_t.
//  - localparams CMD_IMEM=8'hA1, CMD_DMEM=8'hD1, CMD_GO=8'h5A.
//  Sub-module mem_loader_word_asm:
//  - DMEM_DW-wide byte shift register plus byte counter; load/clear inputs; word_full output.
//  - IMEM words take the low IMEM_DW bits.
//  Top: FSM, 16-bit remaining counter, address register, output registers.
// TESTING
//  1 Reset: hold reset_b=0 for 2 cycles -> rx_ready=1, cpu_reset_b=0, all we=0, err=0.
//  2 IMEM frame A1,02,00,10,00,13,05,10,00,B3,85,A5,00, rx_valid continuous:
//    -> imem_we at addr 8'h10 data 32'h00100513, then addr 8'h11 data 32'h00A585B3.
//    -> rx_ready=0 exactly in each WRITE cycle.
//  3 DMEM frame D1,01,00,FF,00 plus 8 bytes 01..08 with rx_valid toggling each cycle:
//    -> one dmem_we at addr 8'hFF, data 64'h0807060504030201.
//  4 Wrap: D1,02,00,FF,00 plus 16 bytes -> writes at 8'hFF then 8'h00.
//    LEN=0 frame A1,00,00,00,00 -> no write; FSM back in IDLE.
//  5 Byte 8'h77 in IDLE -> err=1 and stays 1; a following valid A1 frame still writes.
//  6 Reset mid-word: reset_b=0 after 3 of 4 data bytes -> no imem_we; state IDLE.
//    GO byte 5A -> next cycle cpu_reset_b=1, load_done=1, rx_ready=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream memory loader.
// Contents:
//   ldr_state_t - loader FSM state encoding
//   CMD_*       - frame command bytes
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StAdr0,
        StAdr1,
        StData,
        StWrite,
        StDone
    } ldr_state_t;

    localparam logic [7:0] CMD_IMEM = 8'hA1;
    localparam logic [7:0] CMD_DMEM = 8'hD1;
    localparam logic [7:0] CMD_GO   = 8'h5A;

endpackage

// File: rtl/mem_loader_word_asm.sv
// Word assembler: collects bytes LSB-first into a DMEM_DW-wide register.
// Ports:
//   clk, reset_b  - clock, synchronous active-low reset
//   clear         - drop the current word and restart at byte 0
//   load          - accept byte_in into the next byte lane
//   sel_dmem      - 1: word is DMEM_DW/8 bytes, 0: IMEM_DW/8 bytes
//   byte_in       - incoming byte
//   word          - assembled word (IMEM words occupy the low IMEM_DW bits)
//   word_full     - the byte being loaded this cycle completes the word
module mem_loader_word_asm #(
    parameter int unsigned IMEM_DW = 32,
    parameter int unsigned DMEM_DW = 64
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               clear,
    input  logic               load,
    input  logic               sel_dmem,
    input  logic [7:0]         byte_in,
    output logic [DMEM_DW-1:0] word,
    output logic               word_full
);

    localparam int unsigned DMEM_BYTES = DMEM_DW / 8;
    localparam int unsigned IMEM_BYTES = IMEM_DW / 8;
    localparam int unsigned CW         = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

    logic [CW-1:0]      cnt_q, cnt_d, last_idx;
    logic [DMEM_DW-1:0] word_q, word_d;

    assign last_idx  = sel_dmem ? CW'(DMEM_BYTES - 1) : CW'(IMEM_BYTES - 1);
    assign word_full = load && (cnt_q == last_idx);
    assign word      = word_q;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (load) begin
            // Bytes land in fixed lanes so a short IMEM word ends up in the low bits.
            word_d[{cnt_q, 3'b000} +: 8] = byte_in;
            cnt_d = word_full ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream loader that writes words into IMEM/DMEM and holds the
// CPU in reset until a GO command arrives.
// Frame: CMD, LEN_LO, LEN_HI, ADR_LO, ADR_HI, then LEN words LSB byte first.
// Ports:
//   clk, reset_b             - clock, synchronous active-low reset
//   rx_valid/rx_data/rx_ready - byte link from host
//   imem_we/addr/wdata       - IMEM write port (1-cycle strobe)
//   dmem_we/addr/wdata       - DMEM write port (1-cycle strobe)
//   cpu_reset_b              - active-low CPU reset, released by GO
//   load_done                - GO received; loader is parked
//   err                      - sticky unknown-command flag
module mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_AW = 8,
    parameter int unsigned DMEM_AW = 8,
    parameter int unsigned IMEM_DW = 32,
    parameter int unsigned DMEM_DW = 64
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [IMEM_DW-1:0] imem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DMEM_DW-1:0] dmem_wdata,
    output logic               cpu_reset_b,
    output logic               load_done,
    output logic               err
);

    ldr_state_t state_q, state_d;
    logic        tgt_dmem_q, tgt_dmem_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] addr_q, addr_d;
    logic        err_q, err_d;

    logic               accept;
    logic               asm_load, asm_clear, word_full;
    logic [DMEM_DW-1:0] asm_word;
    logic               unused_addr;

    assign rx_ready = (state_q != StWrite) && (state_q != StDone);
    assign accept   = rx_valid && rx_ready;

    mem_loader_word_asm #(
        .IMEM_DW(IMEM_DW),
        .DMEM_DW(DMEM_DW)
    ) u_word_asm (
        .clk       (clk),
        .reset_b   (reset_b),
        .clear     (asm_clear),
        .load      (asm_load),
        .sel_dmem  (tgt_dmem_q),
        .byte_in   (rx_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    always_comb begin
        state_d    = state_q;
        tgt_dmem_d = tgt_dmem_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        err_d      = err_q;
        asm_load   = 1'b0;
        asm_clear  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (rx_data == CMD_IMEM) begin
                        tgt_dmem_d = 1'b0;
                        state_d    = StLen0;
                    end else if (rx_data == CMD_DMEM) begin
                        tgt_dmem_d = 1'b1;
                        state_d    = StLen0;
                    end else if (rx_data == CMD_GO) begin
                        state_d = StDone;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLen0: begin
                if (accept) begin
                    rem_d[7:0] = rx_data;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    rem_d[15:8] = rx_data;
                    state_d     = StAdr0;
                end
            end
            StAdr0: begin
                if (accept) begin
                    addr_d[7:0] = rx_data;
                    state_d     = StAdr1;
                end
            end
            StAdr1: begin
                if (accept) begin
                    addr_d[15:8] = rx_data;
                    state_d      = (rem_q == 16'd0) ? StIdle : StData;
                end
            end
            StData: begin
                asm_load = accept;
                if (word_full) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Full 16-bit increment; the truncated output slice wraps mod 2^AW.
                addr_d    = addr_q + 16'd1;
                rem_d     = rem_q - 16'd1;
                asm_clear = 1'b1;
                state_d   = (rem_q == 16'd1) ? StIdle : StData;
            end
            StDone: begin
                state_d = StDone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q    <= StIdle;
            tgt_dmem_q <= 1'b0;
            rem_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_dmem_q <= tgt_dmem_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    // Upper address bits beyond the memory widths are accepted and ignored.
    assign unused_addr = ^addr_q;

    assign imem_we     = (state_q == StWrite) && !tgt_dmem_q;
    assign dmem_we     = (state_q == StWrite) && tgt_dmem_q;
    assign imem_addr   = addr_q[IMEM_AW-1:0];
    assign dmem_addr   = addr_q[DMEM_AW-1:0];
    assign imem_wdata  = asm_word[IMEM_DW-1:0];
    assign dmem_wdata  = asm_word;
    assign cpu_reset_b = (state_q == StDone);
    assign load_done   = (state_q == StDone);
    assign err         = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed frames, a frame-level model of
// expected memory writes, and a per-cycle monitor.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we, dmem_we;
    logic [7:0]  imem_addr, dmem_addr;
    logic [31:0] imem_wdata;
    logic [63:0] dmem_wdata;
    logic        cpu_reset_b, load_done, err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_d;
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  payload[$];
    logic [7:0]  log_addr[$];
    logic [63:0] log_data[$];
    bit          exp_go  = 1'b0;
    bit          exp_err = 1'b0;

    always #5 clk = ~clk;

    mem_loader dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .cpu_reset_b (cpu_reset_b),
        .load_done   (load_done),
        .err         (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle monitor, sampled just after the active edge.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_b) begin
                check("cpu_reset_b", cpu_reset_b, exp_go);
                check("load_done", load_done, exp_go);
                check("err", err, exp_err);
                check("rx_ready", rx_ready, !exp_go && !(imem_we || dmem_we));
                if (imem_we || dmem_we) begin
                    check("single_we", imem_we && dmem_we, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_kind", dmem_we, e.is_d);
                        check("wr_addr", dmem_we ? dmem_addr : imem_addr, e.addr);
                        check("wr_data", dmem_we ? dmem_wdata : {32'h0, imem_wdata}, e.data);
                    end
                    log_addr.push_back(dmem_we ? dmem_addr : imem_addr);
                    log_data.push_back(dmem_we ? dmem_wdata : {32'h0, imem_wdata});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'hEE;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rx_ready_timeout", 0, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Model: expected writes come straight from the frame contents.
    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] len,
                              input logic [15:0] adr, input bit gap);
        int  bpw;
        wr_t e;
        bpw = (cmd == 8'hD1) ? 8 : 4;
        for (int w = 0; w < int'(len); w++) begin
            if ((w + 1) * bpw > payload.size()) break;
            e.is_d = (cmd == 8'hD1);
            e.addr = adr[7:0] + 8'(w);
            e.data = '0;
            for (int k = 0; k < bpw; k++) e.data[k*8 +: 8] = payload[w*bpw + k];
            exp_q.push_back(e);
        end
        send_byte(cmd, gap);
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        send_byte(adr[7:0], gap);
        send_byte(adr[15:8], gap);
        foreach (payload[i]) send_byte(payload[i], gap);
        payload.delete();
    endtask

    task automatic log_check(input int idx, input logic [7:0] a, input logic [63:0] d);
        if (idx < log_addr.size()) begin
            check("log_addr", log_addr[idx], a);
            check("log_data", log_data[idx], d);
        end else begin
            check("log_size", log_addr.size(), idx + 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        rx_valid = 1'b0;
        exp_q.delete();
        exp_go  = 1'b0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
    endtask

    initial begin
        // 1 reset
        do_reset();
        check("rst_rx_ready", rx_ready, 1);
        check("rst_cpu_reset_b", cpu_reset_b, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_err", err, 0);
        check("rst_load_done", load_done, 0);

        // 2 IMEM frame, continuous
        payload = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h85, 8'hA5, 8'h00};
        send_frame(8'hA1, 16'd2, 16'h0010, 1'b0);
        repeat (2) @(negedge clk);
        log_check(0, 8'h10, 64'h0000_0000_0010_0513);
        log_check(1, 8'h11, 64'h0000_0000_00A5_85B3);

        // 3 DMEM frame, rx_valid toggling
        payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(8'hD1, 16'd1, 16'h00FF, 1'b1);
        repeat (2) @(negedge clk);
        log_check(2, 8'hFF, 64'h0807_0605_0403_0201);

        // 4 address wrap, then LEN=0
        for (int i = 0; i < 16; i++) payload.push_back(8'(8'h10 + i));
        send_frame(8'hD1, 16'd2, 16'h00FF, 1'b0);
        repeat (2) @(negedge clk);
        log_check(3, 8'hFF, 64'h1716_1514_1312_1110);
        log_check(4, 8'h00, 64'h1F1E_1D1C_1B1A_1918);
        send_frame(8'hA1, 16'd0, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        check("len0_no_write", log_addr.size(), 5);

        // 5 unknown command, then a valid frame
        exp_err = 1'b1;
        send_byte(8'h77, 1'b0);
        check("err_set", err, 1);
        payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(8'hA1, 16'd1, 16'h0030, 1'b0);
        repeat (2) @(negedge clk);
        check("err_sticky", err, 1);
        log_check(5, 8'h30, 64'h0000_0000_EFBE_ADDE);

        // 6 reset mid-word, then GO
        payload = '{8'h11, 8'h22, 8'h33};
        send_frame(8'hA1, 16'd1, 16'h0020, 1'b0);
        do_reset();
        repeat (2) @(negedge clk);
        check("midword_no_write", log_addr.size(), 6);
        check("midword_rx_ready", rx_ready, 1);
        check("midword_cpu_reset_b", cpu_reset_b, 0);
        check("midword_err_cleared", err, 0);
        exp_go = 1'b1;
        send_byte(8'h5A, 1'b0);
        check("go_cpu_reset_b", cpu_reset_b, 1);
        check("go_load_done", load_done, 1);
        check("go_rx_ready", rx_ready, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hA1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        check("done_absorbing", load_done, 1);
        check("exp_queue_empty", exp_q.size(), 0);
        check("total_writes", log_addr.size(), 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
